// File: rtl/mul_m1_m4_pipe_if.sv
// Operand/result bundle between the execute issue logic, the M1..M4 multiplier and M5.
// With MUL_DST_SCOREBOARD_EN defined the bundle also carries busy_mask.
interface mul_m1_m4_pipe_if #(
    parameter int REG_SIZE = 32,
    parameter int DST_W    = 5
);
    logic                in_valid;
    logic [REG_SIZE-1:0] in_a;
    logic [REG_SIZE-1:0] in_b;
    logic [DST_W-1:0]    in_dst;
    logic                stall;
    logic                flush;
    logic [REG_SIZE-1:0] m4result;
    logic                zero;
    logic                overflow;
    logic [DST_W-1:0]    dst;
    logic                m4_valid;
`ifdef MUL_DST_SCOREBOARD_EN
    logic [2**DST_W-1:0] busy_mask;

    modport master (
        output in_valid, in_a, in_b, in_dst, stall, flush,
        input  m4result, zero, overflow, dst, m4_valid, busy_mask
    );
    modport slave (
        input  in_valid, in_a, in_b, in_dst, stall, flush,
        output m4result, zero, overflow, dst, m4_valid, busy_mask
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_dst, stall, flush,
        input  m4result, zero, overflow, dst, m4_valid
    );
    modport slave (
        input  in_valid, in_a, in_b, in_dst, stall, flush,
        output m4result, zero, overflow, dst, m4_valid
    );
`endif
endinterface

// File: rtl/mul_m1_m4_pipe.sv
// Four-stage signed REG_SIZE x REG_SIZE multiplier (M1..M4) feeding M5.
// Optional destination scoreboard output busy_mask under macro MUL_DST_SCOREBOARD_EN.
module mul_m1_m4_pipe #(
    parameter int REG_SIZE = 32,
    parameter int DST_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    mul_m1_m4_pipe_if.slave bus
);
    localparam int H  = REG_SIZE / 2;
    localparam int W2 = 2 * REG_SIZE;

    function automatic logic [REG_SIZE-1:0] f_mag(input logic [REG_SIZE-1:0] v);
        logic [REG_SIZE-1:0] res;
        if (v[REG_SIZE-1]) begin
            res = ~v + {{(REG_SIZE-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    logic                r_m1_valid;
    logic                r_m1_sign;
    logic [DST_W-1:0]    r_m1_dst;
    logic [2*H-1:0]      r_m1_ll;
    logic [2*H-1:0]      r_m1_lh;
    logic [2*H-1:0]      r_m1_hl;
    logic [2*H-1:0]      r_m1_hh;

    logic                r_m2_valid;
    logic                r_m2_sign;
    logic [DST_W-1:0]    r_m2_dst;
    logic [2*H-1:0]      r_m2_ll;
    logic [2*H-1:0]      r_m2_hh;
    logic [2*H:0]        r_m2_cross;

    logic                r_m3_valid;
    logic [DST_W-1:0]    r_m3_dst;
    logic [W2-1:0]       r_m3_prod;

    logic                r_m4_valid;
    logic [DST_W-1:0]    r_m4_dst;
    logic [REG_SIZE-1:0] r_m4_result;
    logic                r_m4_zero;
    logic                r_m4_ovf;

    logic [REG_SIZE-1:0] w_mag_a;
    logic [REG_SIZE-1:0] w_mag_b;
    logic [2*H-1:0]      w_ll;
    logic [2*H-1:0]      w_lh;
    logic [2*H-1:0]      w_hl;
    logic [2*H-1:0]      w_hh;
    logic [W2-1:0]       w_mag;
    logic [W2-1:0]       w_prod;
    logic [REG_SIZE:0]   w_hi;
    logic                w_ovf;

    // Datapath between stage registers: magnitudes, partial products, recombination, sign.
    always_comb begin
        w_mag_a = f_mag(bus.in_a);
        w_mag_b = f_mag(bus.in_b);
        w_ll    = {{H{1'b0}}, w_mag_a[H-1:0]}        * {{H{1'b0}}, w_mag_b[H-1:0]};
        w_lh    = {{H{1'b0}}, w_mag_a[H-1:0]}        * {{H{1'b0}}, w_mag_b[REG_SIZE-1:H]};
        w_hl    = {{H{1'b0}}, w_mag_a[REG_SIZE-1:H]} * {{H{1'b0}}, w_mag_b[H-1:0]};
        w_hh    = {{H{1'b0}}, w_mag_a[REG_SIZE-1:H]} * {{H{1'b0}}, w_mag_b[REG_SIZE-1:H]};
        // hh and ll occupy disjoint halves, so they concatenate; only cross needs an adder.
        w_mag   = {r_m2_hh, r_m2_ll} + {{(H-1){1'b0}}, r_m2_cross, {H{1'b0}}};
        if (r_m2_sign) begin
            w_prod = ~w_mag + {{(W2-1){1'b0}}, 1'b1};
        end else begin
            w_prod = w_mag;
        end
        w_hi  = r_m3_prod[W2-1:REG_SIZE-1];
        w_ovf = ~((&w_hi) | (~|w_hi));
    end

    // Stage registers: reset clears all, flush kills valids (wins over stall), stall holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m1_valid  <= 1'b0;
            r_m1_sign   <= 1'b0;
            r_m1_dst    <= '0;
            r_m1_ll     <= '0;
            r_m1_lh     <= '0;
            r_m1_hl     <= '0;
            r_m1_hh     <= '0;
            r_m2_valid  <= 1'b0;
            r_m2_sign   <= 1'b0;
            r_m2_dst    <= '0;
            r_m2_ll     <= '0;
            r_m2_hh     <= '0;
            r_m2_cross  <= '0;
            r_m3_valid  <= 1'b0;
            r_m3_dst    <= '0;
            r_m3_prod   <= '0;
            r_m4_valid  <= 1'b0;
            r_m4_dst    <= '0;
            r_m4_result <= '0;
            r_m4_zero   <= 1'b0;
            r_m4_ovf    <= 1'b0;
        end else if (bus.flush) begin
            r_m1_valid <= 1'b0;
            r_m2_valid <= 1'b0;
            r_m3_valid <= 1'b0;
            r_m4_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_m1_valid  <= bus.in_valid;
            r_m1_sign   <= bus.in_a[REG_SIZE-1] ^ bus.in_b[REG_SIZE-1];
            r_m1_dst    <= bus.in_dst;
            r_m1_ll     <= w_ll;
            r_m1_lh     <= w_lh;
            r_m1_hl     <= w_hl;
            r_m1_hh     <= w_hh;
            r_m2_valid  <= r_m1_valid;
            r_m2_sign   <= r_m1_sign;
            r_m2_dst    <= r_m1_dst;
            r_m2_ll     <= r_m1_ll;
            r_m2_hh     <= r_m1_hh;
            r_m2_cross  <= {1'b0, r_m1_lh} + {1'b0, r_m1_hl};
            r_m3_valid  <= r_m2_valid;
            r_m3_dst    <= r_m2_dst;
            r_m3_prod   <= w_prod;
            r_m4_valid  <= r_m3_valid;
            r_m4_dst    <= r_m3_dst;
            r_m4_result <= r_m3_prod[REG_SIZE-1:0];
            r_m4_zero   <= (r_m3_prod[REG_SIZE-1:0] == {REG_SIZE{1'b0}});
            r_m4_ovf    <= w_ovf;
        end
    end

    assign bus.m4result = r_m4_result;
    assign bus.zero     = r_m4_zero;
    assign bus.overflow = r_m4_ovf;
    assign bus.dst      = r_m4_dst;
    assign bus.m4_valid = r_m4_valid;

`ifdef MUL_DST_SCOREBOARD_EN
    localparam int NREG = 2 ** DST_W;
    logic [NREG-1:0] w_busy;

    // Union of destinations owned by valid ops in M1..M4; register 0 is never tracked.
    always_comb begin
        w_busy = {NREG{1'b0}};
        w_busy = w_busy | ({{(NREG-1){1'b0}}, r_m1_valid} << r_m1_dst);
        w_busy = w_busy | ({{(NREG-1){1'b0}}, r_m2_valid} << r_m2_dst);
        w_busy = w_busy | ({{(NREG-1){1'b0}}, r_m3_valid} << r_m3_dst);
        w_busy = w_busy | ({{(NREG-1){1'b0}}, r_m4_valid} << r_m4_dst);
        w_busy[0] = 1'b0;
    end

    assign bus.busy_mask = w_busy;
`endif
endmodule
